// File: rtl/cpu_seq_pkg.sv
// Shared constants for the multi-cycle stage sequencer.
// The state encoding is chosen so that bits [4:0] of the state register
// are exactly the one-hot stage enables {wb,mem,ex,id,if}. Bit 5 marks HALT.
// IDLE is all zeros, so the stage enables fall straight out of the state register.
package cpu_seq_pkg;

  // Stage index constants, matching the stage_en bit order
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam int STG_N    = 5;
  localparam int HALT_BIT = 5;
  localparam int STATE_W  = 6;

  // State encoding: low five bits are the stage enables themselves
  localparam logic [STATE_W-1:0] IDLE = 6'b000000;
  localparam logic [STATE_W-1:0] IF   = 6'b000001;
  localparam logic [STATE_W-1:0] ID   = 6'b000010;
  localparam logic [STATE_W-1:0] EX   = 6'b000100;
  localparam logic [STATE_W-1:0] MEM  = 6'b001000;
  localparam logic [STATE_W-1:0] WB   = 6'b010000;
  localparam logic [STATE_W-1:0] HALT = 6'b100000;

endpackage

// File: rtl/seq_retire_counter.sv
// Retired-instruction counter. Increments by one on each inc cycle and
// wraps naturally at 2^CNT_W. Cleared by the synchronous reset.
module seq_retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q;

  // Count register: cleared on reset, bumped on each retirement
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + ONE;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle stage controller: walks IF/ID/EX/MEM/WB as one-hot stage
// enables, stalls IF/MEM on the memory-ready handshakes, skips MEM/WB when
// the decoder says they are unused, counts retirements and halts on request.
// Optional feature macro: SEQ_SINGLE_STEP_EN adds the step port, which runs
// one instruction from IDLE while run is low.
module stage_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int SKIP_MEM = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             need_mem,
  input  logic             need_wb,
  input  logic             halt_req,
  output logic [4:0]       stage_en,
  output logic             instr_done,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               need_mem_q, need_mem_d;
  logic               need_wb_q, need_wb_d;
  logic               retire;
  logic               start;
  logic               visit_mem;

  // A step only matters in IDLE; elsewhere the state machine never looks at start
`ifdef SEQ_SINGLE_STEP_EN
  assign start = run | step;
`else
  assign start = run;
`endif

  // With SKIP_MEM=0 every instruction passes through MEM
  assign visit_mem = need_mem_q | (SKIP_MEM == 0);

  // Next-state logic; retire marks the final stage's fire cycle
  always_comb begin
    state_d    = state_q;
    need_mem_d = need_mem_q;
    need_wb_d  = need_wb_q;
    retire     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = IF;
      end
      IF: begin
        if (imem_ready) state_d = ID;
      end
      ID: begin
        need_mem_d = need_mem;
        need_wb_d  = need_wb;
        state_d    = halt_req ? HALT : EX;
      end
      EX: begin
        if (visit_mem)      state_d = MEM;
        else if (need_wb_q) state_d = WB;
        else                retire  = 1'b1;
      end
      MEM: begin
        if (dmem_ready) begin
          if (need_wb_q) state_d = WB;
          else           retire  = 1'b1;
        end
      end
      WB: begin
        retire = 1'b1;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Retirement decides between fetching again and going idle
    if (retire) state_d = run ? IF : IDLE;
  end

  // State and decoder-flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      need_mem_q <= 1'b0;
      need_wb_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      need_mem_q <= need_mem_d;
      need_wb_q  <= need_wb_d;
    end
  end

  // Moore outputs straight from the state register
  assign stage_en   = state_q[STG_WB:STG_IF];
  assign halted     = state_q[HALT_BIT];
  assign instr_done = retire;

  seq_retire_counter #(
    .CNT_W(CNT_W)
  ) u_retire_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (retire),
    .count(retired)
  );

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: per-cycle vectors with hand-computed
// stage enables, retire pulses, halt flag and retired count.
module tb_stage_sequencer;

  logic        clk;
  logic        rst;
  logic        run;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step;
  logic        step_next;
`endif
  logic        imem_ready;
  logic        dmem_ready;
  logic        need_mem;
  logic        need_wb;
  logic        halt_req;
  logic [4:0]  stage_en;
  logic        instr_done;
  logic        halted;
  logic [31:0] retired;

  int n_vec;
  int n_miscmp;
  int exp_ret;

  stage_sequencer #(
    .CNT_W   (32),
    .SKIP_MEM(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
`ifdef SEQ_SINGLE_STEP_EN
    .step      (step),
`endif
    .imem_ready(imem_ready),
    .dmem_ready(dmem_ready),
    .need_mem  (need_mem),
    .need_wb   (need_wb),
    .halt_req  (halt_req),
    .stage_en  (stage_en),
    .instr_done(instr_done),
    .halted    (halted),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // One cycle: drive inputs at the falling edge, check outputs 1 ns later
  task automatic cyc(input string tag, input logic r, input logic im, input logic dm,
                     input logic nm, input logic nw, input logic hr,
                     input logic [4:0] exp_en, input logic exp_done);
    @(negedge clk);
    rst        = 1'b0;
    run        = r;
    imem_ready = im;
    dmem_ready = dm;
    need_mem   = nm;
    need_wb    = nw;
    halt_req   = hr;
`ifdef SEQ_SINGLE_STEP_EN
    step       = step_next;
`endif
    #1;
    chk({tag, ".en"}, {27'd0, stage_en}, {27'd0, exp_en});
    chk({tag, ".done"}, {31'd0, instr_done}, {31'd0, exp_done});
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst        = 1'b1;
    run        = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    need_mem   = 1'b0;
    need_wb    = 1'b0;
    halt_req   = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step       = 1'b0;
`endif
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec    = 0;
    n_miscmp = 0;
    exp_ret  = 0;
    rst = 1'b1; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    need_mem = 1'b0; need_wb = 1'b0; halt_req = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b0; step_next = 1'b0;
`endif

    // Reset, then idle for 10 cycles with run low
    do_reset(2);
    chk("rst.halted", {31'd0, halted}, 32'd0);
    chk("rst.retired", retired, 32'd0);
    for (int i = 0; i < 10; i++) cyc("idle", 0, 1, 1, 1, 1, 0, 5'b00000, 0);
    chk("idle.retired", retired, 32'd0);
    chk("idle.halted", {31'd0, halted}, 32'd0);

    // ALU op: IF, ID, EX, WB; run dropped in WB so it goes idle afterwards
    cyc("alu.idle", 1, 0, 0, 0, 0, 0, 5'b00000, 0);
    cyc("alu.if",   1, 1, 0, 0, 0, 0, 5'b00001, 0);
    cyc("alu.id",   1, 0, 0, 0, 1, 0, 5'b00010, 0);
    cyc("alu.ex",   1, 0, 0, 0, 0, 0, 5'b00100, 0);
    cyc("alu.wb",   0, 0, 0, 0, 0, 0, 5'b10000, 1);
    exp_ret++;
    cyc("alu.end",  0, 0, 0, 0, 0, 0, 5'b00000, 0);
    chk("alu.retired", retired, exp_ret);

    // Load: MEM held 4 cycles by dmem_ready; ready lines toggled outside their stage
    cyc("ld.idle", 1, 0, 0, 0, 0, 0, 5'b00000, 0);
    cyc("ld.if",   1, 1, 0, 0, 0, 0, 5'b00001, 0);
    cyc("ld.id",   1, 0, 1, 1, 1, 0, 5'b00010, 0);
    cyc("ld.ex",   1, 0, 1, 0, 0, 0, 5'b00100, 0);
    cyc("ld.mem0", 1, 1, 0, 0, 0, 0, 5'b01000, 0);
    cyc("ld.mem1", 1, 1, 0, 0, 0, 0, 5'b01000, 0);
    cyc("ld.mem2", 1, 1, 0, 0, 0, 0, 5'b01000, 0);
    cyc("ld.mem3", 1, 0, 1, 0, 0, 0, 5'b01000, 0);
    cyc("ld.wb",   0, 0, 0, 0, 0, 0, 5'b10000, 1);
    exp_ret++;
    cyc("ld.end",  0, 0, 0, 0, 0, 0, 5'b00000, 0);
    chk("ld.retired", retired, exp_ret);

    // IF stall two cycles, run drops during EX; instruction still finishes
    cyc("st.idle", 1, 0, 0, 0, 0, 0, 5'b00000, 0);
    cyc("st.if0",  1, 0, 1, 0, 0, 0, 5'b00001, 0);
    cyc("st.if1",  1, 0, 1, 0, 0, 0, 5'b00001, 0);
    cyc("st.if2",  1, 1, 0, 0, 0, 0, 5'b00001, 0);
    cyc("st.id",   1, 0, 0, 0, 1, 0, 5'b00010, 0);
    cyc("st.ex",   0, 0, 0, 0, 0, 0, 5'b00100, 0);
    cyc("st.wb",   0, 0, 0, 0, 0, 0, 5'b10000, 1);
    exp_ret++;
    cyc("st.end0", 0, 1, 1, 0, 0, 0, 5'b00000, 0);
    cyc("st.end1", 0, 1, 1, 0, 0, 0, 5'b00000, 0);
    chk("st.retired", retired, exp_ret);

    // No MEM, no WB: retire in EX, back-to-back with run high
    cyc("bb.idle", 1, 0, 0, 0, 0, 0, 5'b00000, 0);
    cyc("bb.if",   1, 1, 0, 0, 0, 0, 5'b00001, 0);
    cyc("bb.id",   1, 0, 0, 0, 0, 0, 5'b00010, 0);
    cyc("bb.ex",   1, 0, 0, 0, 0, 0, 5'b00100, 1);
    exp_ret++;
    cyc("bb.if2a", 0, 0, 0, 0, 0, 0, 5'b00001, 0);
    cyc("bb.if2b", 0, 1, 0, 0, 0, 0, 5'b00001, 0);
    cyc("bb.id2",  0, 0, 0, 0, 0, 0, 5'b00010, 0);
    cyc("bb.ex2",  0, 0, 0, 0, 0, 0, 5'b00100, 1);
    exp_ret++;
    cyc("bb.end",  0, 0, 0, 0, 0, 0, 5'b00000, 0);
    chk("bb.retired", retired, exp_ret);

`ifdef SEQ_SINGLE_STEP_EN
    // Single step from IDLE; a second step during EX is dropped
    step_next = 1'b1;
    cyc("sp.idle", 0, 0, 0, 0, 0, 0, 5'b00000, 0);
    step_next = 1'b0;
    cyc("sp.if",   0, 1, 0, 0, 0, 0, 5'b00001, 0);
    cyc("sp.id",   0, 0, 0, 0, 1, 0, 5'b00010, 0);
    step_next = 1'b1;
    cyc("sp.ex",   0, 0, 0, 0, 0, 0, 5'b00100, 0);
    step_next = 1'b0;
    cyc("sp.wb",   0, 0, 0, 0, 0, 0, 5'b10000, 1);
    exp_ret++;
    cyc("sp.end0", 0, 1, 1, 0, 0, 0, 5'b00000, 0);
    cyc("sp.end1", 0, 1, 1, 0, 0, 0, 5'b00000, 0);
    chk("sp.retired", retired, exp_ret);
`endif

    // Halt in ID: HALT next cycle, run ignored, retired unchanged
    cyc("ht.idle", 1, 0, 0, 0, 0, 0, 5'b00000, 0);
    cyc("ht.if",   1, 1, 0, 0, 0, 0, 5'b00001, 0);
    cyc("ht.id",   1, 0, 0, 1, 1, 1, 5'b00010, 0);
    chk("ht.pre_halted", {31'd0, halted}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc("ht.hold", 1, 1, 1, 0, 0, 0, 5'b00000, 0);
      chk("ht.halted", {31'd0, halted}, 32'd1);
    end
    chk("ht.retired", retired, exp_ret);

    // Only reset leaves HALT
    do_reset(1);
    exp_ret = 0;
    cyc("ht.rst", 0, 0, 0, 0, 0, 0, 5'b00000, 0);
    chk("ht.rst_halted", {31'd0, halted}, 32'd0);
    chk("ht.rst_retired", retired, exp_ret);

    // Reset mid-instruction abandons it and lands in IDLE
    cyc("rm.idle", 1, 0, 0, 0, 0, 0, 5'b00000, 0);
    cyc("rm.if",   1, 1, 0, 0, 0, 0, 5'b00001, 0);
    cyc("rm.id",   1, 0, 0, 1, 1, 0, 5'b00010, 0);
    cyc("rm.ex",   1, 0, 0, 0, 0, 0, 5'b00100, 0);
    @(negedge clk);
    rst = 1'b1;
    run = 1'b1;
    @(posedge clk);
    cyc("rm.after", 0, 1, 1, 0, 0, 0, 5'b00000, 0);
    cyc("rm.stay",  0, 1, 1, 0, 0, 0, 5'b00000, 0);
    chk("rm.retired", retired, 32'd0);
    chk("rm.halted", {31'd0, halted}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
